// File: rtl/text_mode_pkg.sv
// Shared constants, cell word layout and clear-engine state encoding for the text-mode renderer.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
package text_mode_pkg;

    localparam int COLS     = 80;
    localparam int ROWS     = 30;
    localparam int CELLS    = COLS * ROWS;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int PIPE_LAT = 3;

    localparam logic [15:0] BLANK_CELL = 16'h0720;

    // Stored cell word: the two top bits of the CPU word are dropped.
    typedef struct packed {
        logic [2:0] bg;
        logic [2:0] fg;
        logic [7:0] char;
    } cell_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // row*80 + col built from shifts so no multiplier is inferred.
    function automatic logic [11:0] cell_index(input logic [4:0] row, input logic [6:0] col);
        logic [11:0] r;
        r = {7'd0, row};
        return (r << 6) + (r << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/text_mode_renderer_font_rom.sv
// 8x16 glyph ROM addressed by {char, line}; MSB of each byte is the leftmost pixel.
// Latency: 1 cycle (registered read).
// Backpressure: none; a new address is accepted every cycle.
module font_rom (
    input  logic        clk,
    input  logic [11:0] addr,
    output logic [7:0]  glyph
);

    // Glyph table: 'A' and a solid block are populated; every other code (space included) is blank.
    function automatic logic [7:0] glyph_line(input logic [7:0] code, input logic [3:0] line);
        logic [7:0] g;
        g = 8'h00;
        case (code)
            8'h41: begin
                case (line)
                    4'd2:                      g = 8'h10;
                    4'd3:                      g = 8'h38;
                    4'd4:                      g = 8'h6C;
                    4'd5, 4'd6:                g = 8'hC6;
                    4'd7:                      g = 8'hFE;
                    4'd8, 4'd9, 4'd10, 4'd11:  g = 8'hC6;
                    default:                   g = 8'h00;
                endcase
            end
            8'hDB:   g = 8'hFF;
            default: g = 8'h00;
        endcase
        return g;
    endfunction

    // Synchronous read so the ROM maps onto block memory.
    always_ff @(posedge clk) begin
        glyph <= glyph_line(addr[11:4], addr[3:0]);
    end

endmodule

// File: rtl/text_mode_renderer.sv
// Character-cell pixel source: 80x30 cell RAM + font ROM + palette, with CPU write port, clear engine and cursor.
// Latency: coordinates at cycle t produce colour levels at t+3; clear takes 2400 cycles of busy.
// Backpressure: CPU writes stall (no wr_ack) while a clear runs; the pixel pipeline never stalls.
module text_mode_renderer
    import text_mode_pkg::*;
#(
    parameter  int COLOR_DEPTH = 9,
    localparam int CW          = COLOR_DEPTH / 3
) (
    input  logic                   clk_25,
    input  logic                   reset,
    input  logic [31:0]            pxl_x,
    input  logic [31:0]            pxl_y,
    input  logic                   frame,
    input  logic                   wr_req,
    input  logic [11:0]            wr_addr,
    input  logic [15:0]            wr_data,
    output logic                   wr_ack,
    input  logic                   pal_we,
    input  logic [2:0]             pal_idx,
    input  logic [COLOR_DEPTH-1:0] pal_data,
    input  logic                   clear_req,
    output logic                   busy,
    input  logic                   cursor_en,
    input  logic [11:0]            cursor_pos,
    output logic [CW-1:0]          Red_level,
    output logic [CW-1:0]          Green_level,
    output logic [CW-1:0]          Blue_level
);

    localparam logic [11:0] CELLS_12  = 12'(CELLS);
    localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

    clr_state_t             state;
    clr_state_t             state_nxt;
    logic [11:0]            clr_cnt;
    logic                   accept;
    logic                   ram_we;
    logic [11:0]            ram_waddr;
    cell_t                  ram_wdata;
    cell_t                  char_ram [0:CELLS-1];
    logic [COLOR_DEPTH-1:0] palette  [0:7];
    logic [4:0]             blink;
    logic                   unused_wr_bits;

    // Pipeline state
    logic [PIPE_LAT-2:0]    vld_q;
    logic                   in_range;
    logic [11:0]            s0_idx;
    logic [2:0]             s0_xbit;
    logic [3:0]             s0_line;
    cell_t                  s0_cell;
    cell_t                  s1_cell;
    logic [11:0]            s1_idx;
    logic [2:0]             s1_xbit;
    logic [3:0]             s1_line;
    logic [7:0]             s1_glyph;
    logic                   pix_on;
    logic                   cursor_on;
    logic [COLOR_DEPTH-1:0] colour;

    assign unused_wr_bits = ^wr_data[15:14];

    // Clear-engine state register; reset aborts a clear mid-way.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: clear requests only matter in IDLE; CLEAR ends after the last cell.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clear_req) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == LAST_CELL) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy flag, CPU write acceptance and the shared RAM write-port mux.
    always_comb begin
        busy      = (state == CLEAR);
        accept    = (state == IDLE) && wr_req && !clear_req && !wr_ack;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = cell_t'(wr_data[13:0]);
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = cell_t'(BLANK_CELL[13:0]);
        end else if (accept && (wr_addr < CELLS_12)) begin
            ram_we    = 1'b1;
        end
    end

    // Clear address counter: held at 0 outside CLEAR so every clear starts at cell 0.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset)                clr_cnt <= 12'd0;
        else if (state == CLEAR)  clr_cnt <= clr_cnt + 12'd1;
        else                      clr_cnt <= 12'd0;
    end

    // Write acknowledge: one-cycle pulse after the accepting edge (out-of-range addresses are acked too).
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) wr_ack <= 1'b0;
        else       wr_ack <= accept;
    end

    // Character RAM write port; contents survive reset.
    always_ff @(posedge clk_25) begin
        if (ram_we) char_ram[ram_waddr] <= ram_wdata;
    end

    // Palette: 3-bit RGB primaries at reset, CPU-writable afterwards.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                palette[i] <= {{CW{i[2]}}, {CW{i[1]}}, {CW{i[0]}}};
            end
        end else if (pal_we) begin
            palette[pal_idx] <= pal_data;
        end
    end

    // Cursor blink phase counter; bit 4 selects the on half of a 32-frame period.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset)      blink <= 5'd0;
        else if (frame) blink <= blink + 5'd1;
    end

    assign in_range = (pxl_x < H_ACTIVE) && (pxl_y < V_ACTIVE);

    // S0: cell index and glyph coordinates; off-screen pixels index cell 0 and are marked invalid.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            vld_q[0] <= 1'b0;
            s0_idx   <= 12'd0;
            s0_xbit  <= 3'd0;
            s0_line  <= 4'd0;
        end else begin
            vld_q[0] <= in_range;
            s0_idx   <= in_range ? cell_index(pxl_y[8:4], pxl_x[9:3]) : 12'd0;
            s0_xbit  <= pxl_x[2:0];
            s0_line  <= pxl_y[3:0];
        end
    end

    // Asynchronous RAM read so the cell word and its glyph row land in the same stage;
    // a same-cell write on this edge is not seen until the next read (old data).
    assign s0_cell = char_ram[s0_idx];

    font_rom u_font_rom (
        .clk   (clk_25),
        .addr  ({s0_cell.char, s0_line}),
        .glyph (s1_glyph)
    );

    // S1: carry cell attributes alongside the registered glyph row.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            vld_q[1] <= 1'b0;
            s1_cell  <= '0;
            s1_idx   <= 12'd0;
            s1_xbit  <= 3'd0;
            s1_line  <= 4'd0;
        end else begin
            vld_q[1] <= vld_q[0];
            s1_cell  <= s0_cell;
            s1_idx   <= s0_idx;
            s1_xbit  <= s0_xbit;
            s1_line  <= s0_line;
        end
    end

    // S2 colour resolve: glyph bit or lit underline cursor selects foreground.
    always_comb begin
        pix_on    = s1_glyph[3'd7 - s1_xbit];
        cursor_on = cursor_en && (s1_idx == cursor_pos) && (s1_line >= 4'd14) && blink[4];
        colour    = palette[(pix_on || cursor_on) ? s1_cell.fg : s1_cell.bg];
    end

    // S2 output register; invalid (off-screen) pixels are black.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            {Red_level, Green_level, Blue_level} <= '0;
        end else if (vld_q[1]) begin
            {Red_level, Green_level, Blue_level} <= colour;
        end else begin
            {Red_level, Green_level, Blue_level} <= '0;
        end
    end

endmodule
